// File: rtl/disp_scan4.sv
// disp_scan4: multiplexed 4-digit scan driver feeding a 7-segment decoder, with frame-aligned value updates
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   en               1 = scanning; 0 = anodes off, prescaler and digit index frozen
//   load, value_in   one-cycle capture request and the 16-bit value to show
//   nibble, an       registered digit code and active-low digit enables
//   frame_done       one-cycle pulse when the digit index wraps 3 -> 0
//   busy             a captured value is waiting for the next frame boundary
module disp_scan4 #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZB_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        busy
);
    localparam int PW = $clog2(REFRESH_DIV);
    logic [PW-1:0] prescaler;
    logic [1:0]    idx, idx_next;
    logic [15:0]   shadow, disp, disp_next;
    logic          pending, tick, wrap, blank;
    assign tick      = en && prescaler == PW'(REFRESH_DIV - 1);
    assign wrap      = tick && idx == 2'd3;
    assign idx_next  = tick ? idx + 2'd1 : idx;
    // a load landing on the wrap tick bypasses the shadow so it is not lost
    assign disp_next = wrap ? (load ? value_in : pending ? shadow : disp) : disp;
    // a digit is a leading zero when it and every more significant digit are 0
    assign blank     = LZB_EN && (idx_next == 2'd3 ? disp_next[15:12] == 4'd0 :
                                  idx_next == 2'd2 ? disp_next[15:8]  == 8'd0 :
                                  idx_next == 2'd1 ? disp_next[15:4]  == 12'd0 : 1'b0);
    assign busy      = pending;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= 2'd0;
            shadow     <= 16'd0;
            disp       <= 16'd0;
            pending    <= 1'b0;
            nibble     <= 4'd0;
            an         <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            if (en) prescaler <= tick ? '0 : prescaler + 1'b1;
            if (load) shadow <= value_in;
            idx        <= idx_next;
            disp       <= disp_next;
            pending    <= wrap ? 1'b0 : (load | pending);
            frame_done <= wrap;
            nibble     <= disp_next[{idx_next, 2'b00} +: 4];
            an         <= (en && !blank) ? ~(4'b0001 << idx_next) : 4'b1111;
        end
    end
endmodule
